// File: rtl/memory_stage.sv
// Memory pipeline stage: takes one instruction from execute, runs loads/stores over a req/gnt/rvalid port, and hands a registered result to writeback.
// Optional define MEM_MISALIGN_TRAP_EN turns misaligned half/word accesses into a flagged result (wb_exc) without a memory request.
module memory_stage #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ex_valid,
    output logic                  ex_ready,
    input  logic [DATA_WIDTH-1:0] ex_alu_result,
    input  logic [DATA_WIDTH-1:0] ex_rs2_data,
    input  logic [6:0]            ex_opcode,
    input  logic [2:0]            ex_funct3,
    input  logic [4:0]            ex_rd,
    output logic                  dmem_req,
    output logic                  dmem_we,
    output logic [ADDR_WIDTH-1:0] dmem_addr,
    output logic [DATA_WIDTH-1:0] dmem_wdata,
    output logic [3:0]            dmem_be,
    input  logic                  dmem_gnt,
    input  logic                  dmem_rvalid,
    input  logic [DATA_WIDTH-1:0] dmem_rdata,
    output logic                  wb_valid,
    input  logic                  wb_ready,
    output logic [DATA_WIDTH-1:0] wb_data,
    output logic [4:0]            wb_rd,
    output logic                  wb_reg_write,
    output logic                  wb_exc
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;
    localparam logic [1:0] S_OUT  = 2'd3;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    logic [1:0]            state_reg;
    logic [ADDR_WIDTH-1:0] addr_reg;
    logic [DATA_WIDTH-1:0] rs2_reg;
    logic [2:0]            funct3_reg;
    logic                  is_store_reg;

    logic                  accept;
    logic                  new_is_load;
    logic                  new_is_store;
    logic                  new_is_mem;
    logic                  new_misaligned;
    logic [1:0]            off;
    logic [7:0]            rdata_byte [4];
    logic [7:0]            sel_byte;
    logic [15:0]           sel_half;
    logic [DATA_WIDTH-1:0] load_data;

    // Ready drops during reset so nothing is accepted while the stage is held.
    assign ex_ready     = !rst && ((state_reg == S_IDLE) || (state_reg == S_OUT && wb_ready));
    assign accept       = ex_valid && ex_ready;
    assign new_is_load  = (ex_opcode == OP_LOAD);
    assign new_is_store = (ex_opcode == OP_STORE);
    assign new_is_mem   = new_is_load || new_is_store;
    assign wb_valid     = (state_reg == S_OUT);

`ifdef MEM_MISALIGN_TRAP_EN
    logic new_half;
    logic new_word;
    assign new_half = new_is_load ? (ex_funct3[1:0] == 2'b01) : (ex_funct3 == 3'b001);
    assign new_word = new_is_load ? ex_funct3[1] : (ex_funct3[2] || ex_funct3[1]);
    assign new_misaligned = new_is_mem &&
                            ((new_half && ex_alu_result[0]) ||
                             (new_word && (ex_alu_result[1:0] != 2'b00)));
`else
    assign new_misaligned = 1'b0;
`endif

    assign off = addr_reg[1:0];

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign rdata_byte[gi] = dmem_rdata[8*gi +: 8];
        end
    endgenerate

    assign sel_byte = rdata_byte[off];
    assign sel_half = off[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];

    always_comb begin
        case (funct3_reg)
            3'b000:  load_data = {{(DATA_WIDTH-8){sel_byte[7]}}, sel_byte};
            3'b100:  load_data = {{(DATA_WIDTH-8){1'b0}}, sel_byte};
            3'b001:  load_data = {{(DATA_WIDTH-16){sel_half[15]}}, sel_half};
            3'b101:  load_data = {{(DATA_WIDTH-16){1'b0}}, sel_half};
            default: load_data = dmem_rdata;
        endcase
    end

    // The request bus is only non-zero in REQ, so it stays stable until gnt and clears with reset.
    always_comb begin
        dmem_req   = 1'b0;
        dmem_we    = 1'b0;
        dmem_addr  = '0;
        dmem_wdata = '0;
        dmem_be    = 4'b0000;
        if (state_reg == S_REQ) begin
            dmem_req  = 1'b1;
            dmem_we   = is_store_reg;
            dmem_addr = {addr_reg[ADDR_WIDTH-1:2], 2'b00};
            dmem_be   = 4'b1111;
            if (is_store_reg) begin
                case (funct3_reg)
                    3'b000: begin
                        dmem_wdata = {4{rs2_reg[7:0]}};
                        dmem_be    = 4'b0001 << off;
                    end
                    3'b001: begin
                        dmem_wdata = {2{rs2_reg[15:0]}};
                        dmem_be    = 4'b0011 << {off[1], 1'b0};
                    end
                    default: dmem_wdata = rs2_reg;
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= S_IDLE;
            addr_reg     <= '0;
            rs2_reg      <= '0;
            funct3_reg   <= '0;
            is_store_reg <= 1'b0;
            wb_data      <= '0;
            wb_rd        <= '0;
            wb_reg_write <= 1'b0;
            wb_exc       <= 1'b0;
        end else if (accept) begin
            addr_reg     <= ex_alu_result[ADDR_WIDTH-1:0];
            rs2_reg      <= ex_rs2_data;
            funct3_reg   <= ex_funct3;
            is_store_reg <= new_is_store;
            wb_data      <= ex_alu_result;
            wb_rd        <= ex_rd;
            wb_reg_write <= !new_is_store && (ex_rd != 5'd0) && !new_misaligned;
            wb_exc       <= new_misaligned;
            state_reg    <= (new_is_mem && !new_misaligned) ? S_REQ : S_OUT;
        end else begin
            case (state_reg)
                S_REQ: begin
                    if (dmem_gnt) begin
                        state_reg <= is_store_reg ? S_OUT : S_RESP;
                    end
                end
                S_RESP: begin
                    if (dmem_rvalid) begin
                        wb_data   <= load_data;
                        state_reg <= S_OUT;
                    end
                end
                S_OUT: begin
                    if (wb_ready) begin
                        state_reg <= S_IDLE;
                    end
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_memory_stage.sv
// Scoreboard bench for memory_stage: a byte-addressed reference model predicts results, a memory responder serves requests, a monitor checks writeback.
module tb_memory_stage;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_ALU   = 7'b0110011;
    localparam logic [6:0] OP_ALUI  = 7'b0010011;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid;
    logic        ex_ready;
    logic [31:0] ex_alu_result;
    logic [31:0] ex_rs2_data;
    logic [6:0]  ex_opcode;
    logic [2:0]  ex_funct3;
    logic [4:0]  ex_rd;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_gnt;
    logic        dmem_rvalid;
    logic [31:0] dmem_rdata;
    logic        wb_valid;
    logic        wb_ready;
    logic [31:0] wb_data;
    logic [4:0]  wb_rd;
    logic        wb_reg_write;
    logic        wb_exc;

    memory_stage dut (
        .clk(clk), .rst(rst),
        .ex_valid(ex_valid), .ex_ready(ex_ready),
        .ex_alu_result(ex_alu_result), .ex_rs2_data(ex_rs2_data),
        .ex_opcode(ex_opcode), .ex_funct3(ex_funct3), .ex_rd(ex_rd),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_gnt(dmem_gnt),
        .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_data(wb_data),
        .wb_rd(wb_rd), .wb_reg_write(wb_reg_write), .wb_exc(wb_exc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        logic [4:0]  rd;
        logic        rw;
        logic        exc;
    } wb_exp_t;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
    } req_exp_t;

    wb_exp_t  wb_q[$];
    req_exp_t req_q[$];

    logic [7:0]  mbytes [1024];
    logic [31:0] dmem [256];

    int tests = 0;
    int fails = 0;
    int fixed_wait = -1;
    int fixed_rdelay = -1;
    int wb_mode = 0;
    int streak = 0;
    int max_streak = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
        end
    endtask

    task automatic set_word(input int idx, input logic [31:0] w);
        dmem[idx] = w;
        for (int k = 0; k < 4; k++) mbytes[4*idx+k] = w[8*k +: 8];
    endtask

    // Reference model: memory is a flat byte array; accesses are n bytes at the address rounded down to n.
    function automatic void model_issue(input logic [6:0] op, input logic [2:0] f3, input logic [4:0] rd,
                                        input logic [31:0] alu, input logic [31:0] rs2);
        wb_exp_t  w;
        req_exp_t r;
        int n;
        int base;
        bit sgn;
        logic [31:0] v;
        w.data = alu;
        w.rd   = rd;
        w.rw   = (rd != 5'd0);
        w.exc  = 1'b0;
        if (op == OP_LOAD || op == OP_STORE) begin
            if (op == OP_LOAD) begin
                n   = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
                sgn = !f3[2];
            end else begin
                n   = (f3 == 3'b000) ? 1 : (f3 == 3'b001) ? 2 : 4;
                sgn = 1'b0;
            end
            base = (int'(alu[9:0]) / n) * n;
`ifdef MEM_MISALIGN_TRAP_EN
            if ((int'(alu[9:0]) % n) != 0) begin
                w.exc = 1'b1;
                w.rw  = 1'b0;
                wb_q.push_back(w);
                return;
            end
`endif
            r.addr  = {alu[31:2], 2'b00};
            r.we    = (op == OP_STORE);
            r.be    = 4'b0000;
            r.wdata = 32'h0;
            if (op == OP_STORE) begin
                w.rw = 1'b0;
                for (int k = 0; k < n; k++) begin
                    mbytes[base+k] = rs2[8*k +: 8];
                    r.be[(base+k) % 4] = 1'b1;
                end
                for (int l = 0; l < 4; l++) r.wdata[8*l +: 8] = rs2[8*(l % n) +: 8];
            end else begin
                v = 32'h0;
                for (int k = 0; k < n; k++) v[8*k +: 8] = mbytes[base+k];
                if (sgn && n < 4 && v[8*n-1]) begin
                    for (int b = 8*n; b < 32; b++) v[b] = 1'b1;
                end
                w.data = v;
            end
            req_q.push_back(r);
        end
        wb_q.push_back(w);
    endfunction

    task automatic issue(input logic [6:0] op, input logic [2:0] f3, input logic [4:0] rd,
                         input logic [31:0] alu, input logic [31:0] rs2);
        int n = 0;
        ex_valid      = 1'b1;
        ex_opcode     = op;
        ex_funct3     = f3;
        ex_rd         = rd;
        ex_alu_result = alu;
        ex_rs2_data   = rs2;
        @(negedge clk);
        while (!ex_ready && n < 200) begin
            n++;
            @(negedge clk);
        end
        if (!ex_ready) begin
            tests++;
            fails++;
            $display("FAIL issue_timeout: ex_ready got 0 for 200 cycles, required 1");
        end else begin
            model_issue(op, f3, rd, alu, rs2);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string tag);
        int n = 0;
        ex_valid = 1'b0;
        wb_mode  = 0;
        while ((wb_q.size() != 0 || req_q.size() != 0) && n < 2000) begin
            n++;
            @(negedge clk);
        end
        chk({tag, "_pending_results"}, wb_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_wb(input string tag, input logic [31:0] exp_data);
        int n = 0;
        @(negedge clk);
        while (!wb_valid && n < 50) begin
            n++;
            @(negedge clk);
        end
        chk({tag, "_wb_valid"}, wb_valid, 1);
        chk({tag, "_wb_data"}, wb_data, exp_data);
        @(posedge clk);
        #1;
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_ex_ready"}, ex_ready, 0);
        chk({tag, "_dmem_req"}, dmem_req, 0);
        chk({tag, "_dmem_we"}, dmem_we, 0);
        chk({tag, "_dmem_be"}, dmem_be, 0);
        chk({tag, "_dmem_addr"}, dmem_addr, 0);
        chk({tag, "_dmem_wdata"}, dmem_wdata, 0);
        chk({tag, "_wb_valid"}, wb_valid, 0);
        chk({tag, "_wb_data"}, wb_data, 0);
        chk({tag, "_wb_rd"}, wb_rd, 0);
        chk({tag, "_wb_reg_write"}, wb_reg_write, 0);
        chk({tag, "_wb_exc"}, wb_exc, 0);
    endtask

    // Writeback ready generator.
    initial begin : ready_gen
        forever begin
            @(posedge clk);
            #1;
            if (wb_mode == 0) wb_ready = 1'b1;
            else if (wb_mode == 1) wb_ready = ($urandom_range(0, 3) != 0);
        end
    end

    // Data-memory responder: checks each request against the model, then grants and returns data.
    initial begin : responder
        req_exp_t cur;
        bit cur_ok = 0;
        bit active = 0;
        int wait_left = 0;
        bit rd_pending = 0;
        int rd_cnt = 0;
        logic [31:0] rd_word = 0;
        dmem_gnt    = 1'b0;
        dmem_rvalid = 1'b0;
        dmem_rdata  = 32'h0;
        forever begin
            @(negedge clk);
            dmem_rvalid = 1'b0;
            if (rd_pending) begin
                if (rd_cnt == 0) begin
                    dmem_rvalid = 1'b1;
                    dmem_rdata  = rd_word;
                    rd_pending  = 0;
                end else begin
                    rd_cnt--;
                end
            end
            dmem_gnt = 1'b0;
            if (rst) begin
                active = 0;
            end else if (dmem_req) begin
                if (!active) begin
                    if (req_q.size() == 0) begin
                        tests++;
                        fails++;
                        cur_ok = 0;
                        $display("FAIL unexpected_req: got request to 0x%08h, required none", dmem_addr);
                    end else begin
                        cur    = req_q.pop_front();
                        cur_ok = 1;
                    end
                    active    = 1;
                    wait_left = (fixed_wait >= 0) ? fixed_wait : $urandom_range(0, 3);
                end
                if (cur_ok) begin
                    chk("req_addr", dmem_addr, cur.addr);
                    chk("req_we", dmem_we, cur.we);
                    if (cur.we) begin
                        chk("req_be", dmem_be, cur.be);
                        chk("req_wdata", dmem_wdata, cur.wdata);
                    end
                end
                if (wait_left == 0) begin
                    dmem_gnt = 1'b1;
                    active   = 0;
                    if (dmem_we) begin
                        for (int b = 0; b < 4; b++)
                            if (dmem_be[b]) dmem[dmem_addr[9:2]][8*b +: 8] = dmem_wdata[8*b +: 8];
                    end else begin
                        rd_word    = dmem[dmem_addr[9:2]];
                        rd_pending = 1;
                        rd_cnt     = (fixed_rdelay >= 0) ? fixed_rdelay : $urandom_range(0, 3);
                    end
                end else begin
                    wait_left--;
                end
            end
        end
    end

    // Writeback monitor: every accepted result must match the oldest prediction.
    initial begin : monitor
        wb_exp_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                streak = 0;
            end else begin
                streak = wb_valid ? streak + 1 : 0;
                if (streak > max_streak) max_streak = streak;
                if (wb_valid && wb_ready) begin
                    if (wb_q.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL unexpected_wb: got rd=%0d data=0x%08h, required no result", wb_rd, wb_data);
                    end else begin
                        e = wb_q.pop_front();
                        chk("wb_data", wb_data, e.data);
                        chk("wb_rd", wb_rd, e.rd);
                        chk("wb_reg_write", wb_reg_write, e.rw);
                        chk("wb_exc", wb_exc, e.exc);
                        $display("[TB] result rd=%0d data=0x%08h we=%0b exc=%0b", wb_rd, wb_data, wb_reg_write, wb_exc);
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #5ms;
        $display("FAIL watchdog: simulation got no end, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int n;
        logic [6:0] op;
        rst = 1'b1;
        wb_ready = 1'b1;
        ex_valid = 1'b0;
        ex_opcode = 7'h0;
        ex_funct3 = 3'h0;
        ex_rd = 5'h0;
        ex_alu_result = 32'h0;
        ex_rs2_data = 32'h0;
        for (int i = 0; i < 256; i++) set_word(i, $urandom);
        repeat (3) @(negedge clk);
        chk_zero_outputs("reset");
        rst = 1'b0;
        #1;
        chk("post_reset_ex_ready", ex_ready, 1);
        @(posedge clk);
        #1;

        // ALU op: one-cycle latency, no memory traffic.
        issue(OP_ALU, 3'b000, 5'd5, 32'h0000_1234, 32'h0);
        ex_valid = 1'b0;
        @(negedge clk);
        chk("add_wb_valid", wb_valid, 1);
        chk("add_wb_data", wb_data, 32'h0000_1234);
        chk("add_wb_reg_write", wb_reg_write, 1);
        chk("add_dmem_req", dmem_req, 0);
        @(posedge clk);
        #1;

        // Three back-to-back ALU ops produce three consecutive valid cycles.
        @(negedge clk);
        max_streak = 0;
        @(posedge clk);
        #1;
        issue(OP_ALU, 3'b000, 5'd1, 32'h11, 32'h0);
        issue(OP_ALUI, 3'b000, 5'd2, 32'h22, 32'h0);
        issue(OP_ALU, 3'b000, 5'd3, 32'h33, 32'h0);
        ex_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("b2b_valid_streak", max_streak, 3);
        @(posedge clk);
        #1;

        // SB to 0x103 with two wait states before gnt.
        fixed_wait = 2;
        issue(OP_STORE, 3'b000, 5'd4, 32'h0000_0103, 32'hAABB_CCDD);
        ex_valid = 1'b0;
        n = 0;
        @(negedge clk);
        while (!wb_valid && n < 20) begin
            if (dmem_req) n++;
            @(negedge clk);
        end
        chk("sb_req_cycles", n, 3);
        chk("sb_wb_reg_write", wb_reg_write, 0);
        fixed_wait = -1;
        @(posedge clk);
        #1;

        // Sign/zero extended byte and halfword loads.
        set_word(32'h200 >> 2, 32'h0080_0000);
        issue(OP_LOAD, 3'b000, 5'd6, 32'h0000_0202, 32'h0);
        ex_valid = 1'b0;
        wait_wb("lb", 32'hFFFF_FF80);
        issue(OP_LOAD, 3'b100, 5'd6, 32'h0000_0202, 32'h0);
        ex_valid = 1'b0;
        wait_wb("lbu", 32'h0000_0080);
        drain("lb");
        set_word(32'h200 >> 2, 32'h8001_0000);
        issue(OP_LOAD, 3'b001, 5'd8, 32'h0000_0202, 32'h0);
        ex_valid = 1'b0;
        wait_wb("lh", 32'hFFFF_8001);
        drain("lh");

        // Writeback stall: result held, ex_ready low until wb_ready returns.
        wb_mode = 2;
        wb_ready = 1'b0;
        set_word(32'h40 >> 2, 32'h1357_9BDF);
        issue(OP_LOAD, 3'b010, 5'd7, 32'h0000_0040, 32'h0);
        ex_valid = 1'b0;
        n = 0;
        @(negedge clk);
        while (!wb_valid && n < 50) begin
            n++;
            @(negedge clk);
        end
        for (int i = 0; i < 3; i++) begin
            chk("stall_wb_valid", wb_valid, 1);
            chk("stall_wb_data", wb_data, 32'h1357_9BDF);
            chk("stall_ex_ready", ex_ready, 0);
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        wb_ready = 1'b1;
        #1;
        chk("stall_release_ex_ready", ex_ready, 1);
        @(posedge clk);
        #1;
        wb_mode = 0;
        drain("stall");

        // Reset while waiting for load data; the late rvalid must be ignored.
        fixed_wait = 0;
        fixed_rdelay = 4;
        issue(OP_LOAD, 3'b010, 5'd9, 32'h0000_0010, 32'h0);
        ex_valid = 1'b0;
        n = 0;
        @(negedge clk);
        while (!dmem_req && n < 20) begin
            n++;
            @(negedge clk);
        end
        @(negedge clk);
        chk("resp_req_dropped", dmem_req, 0);
        #2;
        rst = 1'b1;
        #1;
        chk_zero_outputs("midreset");
        wb_q.delete();
        req_q.delete();
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("late_rvalid_no_wb", wb_valid, 0);
        end
        fixed_wait = -1;
        fixed_rdelay = -1;
        @(posedge clk);
        #1;

`ifdef MEM_MISALIGN_TRAP_EN
        issue(OP_LOAD, 3'b010, 5'd3, 32'h0000_0301, 32'h0);
        ex_valid = 1'b0;
        @(negedge clk);
        chk("misalign_wb_valid", wb_valid, 1);
        chk("misalign_wb_exc", wb_exc, 1);
        chk("misalign_wb_data", wb_data, 32'h0000_0301);
        chk("misalign_reg_write", wb_reg_write, 0);
        chk("misalign_no_req", dmem_req, 0);
        @(posedge clk);
        #1;
        drain("misalign");
`endif

        // Randomized mix with random gnt/rvalid latency and writeback back-pressure.
        wb_mode = 1;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                ex_valid = 1'b0;
                @(posedge clk);
                #1;
            end
            case ($urandom_range(0, 3))
                0:       op = OP_ALU;
                1:       op = OP_ALUI;
                2:       op = OP_LOAD;
                default: op = OP_STORE;
            endcase
            issue(op, 3'($urandom_range(0, 7)), 5'($urandom_range(0, 31)),
                  {22'h0, 10'($urandom_range(0, 1023))}, $urandom);
        end
        drain("random");
        chk("random_pending_requests", req_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
